// File: rtl/c3lib_ckg_ctl_pkg.sv
// rtl/c3lib_ckg_ctl_pkg.sv - shared types and helpers for the clock-gate request controller
package c3lib_ckg_ctl_pkg;

    typedef enum logic [1:0] {
        CKG_OFF,
        CKG_WAKE,
        CKG_ON,
        CKG_HOLD
    } ckg_state_e;

    // Settle counter must hold ON_DLY-1; keep at least one bit so ON_DLY=1 still elaborates.
    function automatic int ckg_settle_w(input int on_dly);
        return (on_dly > 1) ? $clog2(on_dly) : 1;
    endfunction

endpackage

// File: rtl/c3lib_ckg_posedge_ctn.sv
// rtl/c3lib_ckg_posedge_ctn.sv - latch-based posedge clock-gate cell
module c3lib_ckg_posedge_ctn (
    input  logic tst_en,
    input  logic clk_en,
    input  logic clk,
    output logic gated_clk
);

    logic en_lat;

    // Transparent while clk is low so the enable only takes effect at the next rising edge.
    always_latch begin
        if (!clk) begin
            en_lat <= clk_en | tst_en;
        end
    end

    assign gated_clk = clk & en_lat;

endmodule

// File: rtl/c3lib_ckg_req_ctl.sv
// rtl/c3lib_ckg_req_ctl.sv - four-phase request/ack controller driving a posedge clock gate
module c3lib_ckg_req_ctl
    import c3lib_ckg_ctl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ON_DLY  = 2,
    parameter int IDLE_W  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tst_en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDLE_W-1:0]  idle_thresh,
    output logic [NUM_REQ-1:0] ack,
    output logic               clk_en,
    output logic               gated_clk
);

    localparam int SETTLE_W = ckg_settle_w(ON_DLY);
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(ON_DLY - 1);

    ckg_state_e          state_q;
    logic                clk_en_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [IDLE_W-1:0]   idle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CKG_OFF;
            clk_en_q <= 1'b0;
            ack_q    <= '0;
            settle_q <= '0;
            idle_q   <= '0;
        end else begin
            case (state_q)
                CKG_OFF: begin
                    clk_en_q <= 1'b0;
                    ack_q    <= '0;
                    if (|req) begin
                        state_q  <= CKG_WAKE;
                        clk_en_q <= 1'b1;
                        settle_q <= SETTLE_INIT;
                    end
                end
                CKG_WAKE: begin
                    // Settle always runs to completion so the gated domain sees ON_DLY clean edges.
                    clk_en_q <= 1'b1;
                    ack_q    <= '0;
                    if (settle_q == '0) begin
                        if (|req) begin
                            state_q <= CKG_ON;
                            ack_q   <= req;
                        end else begin
                            state_q <= CKG_HOLD;
                            idle_q  <= idle_thresh;
                        end
                    end else begin
                        settle_q <= settle_q - SETTLE_W'(1);
                    end
                end
                CKG_ON: begin
                    clk_en_q <= 1'b1;
                    ack_q    <= req;
                    if (~|req) begin
                        state_q <= CKG_HOLD;
                        idle_q  <= idle_thresh;
                    end
                end
                CKG_HOLD: begin
                    clk_en_q <= 1'b1;
                    ack_q    <= '0;
                    if (|req) begin
                        state_q <= CKG_ON;
                        ack_q   <= req;
                    end else if (idle_q == '0) begin
                        state_q  <= CKG_OFF;
                        clk_en_q <= 1'b0;
                    end else begin
                        idle_q <= idle_q - IDLE_W'(1);
                    end
                end
                default: begin
                    state_q  <= CKG_OFF;
                    clk_en_q <= 1'b0;
                    ack_q    <= '0;
                end
            endcase
        end
    end

    assign ack    = ack_q;
    assign clk_en = clk_en_q;

    c3lib_ckg_posedge_ctn u_ctn (
        .tst_en    (tst_en),
        .clk_en    (clk_en_q),
        .clk       (clk),
        .gated_clk (gated_clk)
    );

endmodule

// File: tb/tb_c3lib_ckg_req_ctl.sv
// tb/tb_c3lib_ckg_req_ctl.sv - self-checking bench for c3lib_ckg_req_ctl
module tb_c3lib_ckg_req_ctl;

    localparam int NR = 4;
    localparam int OD = 2;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tst_en = 1'b0;
    logic [NR-1:0] req = '0;
    logic [IW-1:0] idle_thresh = 6'd5;
    logic [NR-1:0] ack;
    logic          clk_en;
    logic          gated_clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    c3lib_ckg_req_ctl #(.NUM_REQ(NR), .ON_DLY(OD), .IDLE_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tst_en      (tst_en),
        .req         (req),
        .idle_thresh (idle_thresh),
        .ack         (ack),
        .clk_en      (clk_en),
        .gated_clk   (gated_clk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Gate open/closed plus how much of the wake or idle time is left; acks follow requests only while serving.
    typedef struct {
        bit          en;
        bit [NR-1:0] ack;
        int          wake_left;
        bit          serving;
        int          idle_left;
        bit          g;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_step(input mdl_t c, input logic [NR-1:0] r, input int thr, input logic te);
        mdl_t n;
        n = c;
        n.g = c.en | te;
        if (!c.en) begin
            n.ack = '0;
            if (r != 0) begin
                n.en = 1'b1;
                n.wake_left = OD;
            end
        end else if (c.wake_left > 0) begin
            n.wake_left = c.wake_left - 1;
            if (n.wake_left == 0) begin
                if (r != 0) begin
                    n.serving = 1'b1;
                    n.ack = r;
                end else begin
                    n.idle_left = thr;
                end
            end
        end else if (c.serving) begin
            n.ack = r;
            if (r == 0) begin
                n.serving = 1'b0;
                n.idle_left = thr;
            end
        end else begin
            if (r != 0) begin
                n.serving = 1'b1;
                n.ack = r;
            end else if (c.idle_left == 0) begin
                n.en = 1'b0;
            end else begin
                n.idle_left = c.idle_left - 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= mdl_step(m, req, int'(idle_thresh), tst_en);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_ack", ack, m.ack);
            chk("model_clk_en", clk_en, m.en);
            chk("gclk_low_phase", gated_clk, 1'b0);
        end
    end

    always @(posedge clk) begin
        if (chk_on) begin
            #1;
            chk("model_gclk", gated_clk, m.g);
        end
    end

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int off_edge;
        bit en_ok;

        edge_();
        chk_on = 1'b1;
        edge_();
        chk("rst_clk_en", clk_en, 1'b0);
        chk("rst_ack", ack, 4'b0000);
        rst_n = 1'b1;
        edge_();
        chk("idle_off", clk_en, 1'b0);

        req = 4'b0001;
        edge_();
        chk("cold_e1_en", clk_en, 1'b1);
        chk("cold_e1_ack", ack, 4'b0000);
        chk("cold_e1_gclk", gated_clk, 1'b0);
        edge_();
        chk("cold_e2_ack", ack, 4'b0000);
        chk("cold_e2_gclk", gated_clk, 1'b1);
        edge_();
        chk("cold_e3_ack", ack, 4'b0001);

        req = 4'b1000;
        edge_();
        chk("overlap_ack", ack, 4'b1000);
        chk("overlap_en", clk_en, 1'b1);
        req = 4'b0011;
        edge_();
        chk("warm_ack", ack, 4'b0011);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ack", ack, 4'b0000);
        chk("arst_en", clk_en, 1'b0);
        chk("arst_gclk", gated_clk, 1'b0);
        req = 4'b0000;
        repeat (2) edge_();
        chk("arst_gclk_held", gated_clk, 1'b0);
        rst_n = 1'b1;
        edge_();
        chk("post_rst_off", clk_en, 1'b0);

        req = 4'b0001;
        repeat (3) edge_();
        chk("hyst_ack_on", ack, 4'b0001);
        idle_thresh = 6'd5;
        req = 4'b0000;
        pulses = 0;
        off_edge = 0;
        for (int k = 1; k <= 12; k++) begin
            edge_();
            if (gated_clk) pulses++;
            if (off_edge == 0 && !clk_en) off_edge = k;
        end
        chk("hyst_off_edge", off_edge, 7);
        chk("hyst_pulses", pulses, 7);

        req = 4'b0010;
        edge_();
        req = 4'b0000;
        repeat (2) edge_();
        chk("wake_drop_ack", ack, 4'b0000);
        chk("wake_drop_en", clk_en, 1'b1);
        repeat (8) edge_();
        chk("wake_drop_off", clk_en, 1'b0);

        idle_thresh = 6'd3;
        req = 4'b0100;
        repeat (3) edge_();
        chk("rereq_ack_on", ack, 4'b0100);
        req = 4'b0000;
        en_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            edge_();
            en_ok &= clk_en;
        end
        req = 4'b0100;
        edge_();
        chk("rereq_ack", ack, 4'b0100);
        chk("rereq_en_kept", en_ok & clk_en, 1'b1);

        idle_thresh = 6'd0;
        req = 4'b0000;
        edge_();
        chk("thr0_e1_en", clk_en, 1'b1);
        edge_();
        chk("thr0_e2_off", clk_en, 1'b0);

        tst_en = 1'b1;
        pulses = 0;
        repeat (4) begin
            edge_();
            if (gated_clk) pulses++;
        end
        chk("tst_pulses", pulses, 4);
        chk("tst_en_low", clk_en, 1'b0);
        chk("tst_ack_low", ack, 4'b0000);
        tst_en = 1'b0;
        repeat (2) edge_();
        chk("tst_off_gclk", gated_clk, 1'b0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
